dsc_mul_seq: RTL and testbench

- Sequencer for one stochastic-computing multiplier datapath (two by-2 SNGs, a 4-lane AND multiplier and a parallel accumulator).
- Accepts operand pairs over a valid/ready handshake and holds them stable.
- Clears and enables the datapath, watches its overflow/early-shutoff flag, drains the accumulator, then returns the binary product over a valid/ready handshake.
- Sits between the host/test logic and one multiplier instance. It owns all datapath reset and enable timing.

---
 rtl/dsc_pkg.sv | 21 ++
 rtl/dsc_run_ctr.sv | 56 +++++
 rtl/dsc_mul_seq.sv | 197 +++++++++++++++++++
 tb/tb_dsc_mul_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic-computing multiplier sequencer.
//   - dsc_state_e : controller state encoding (IDLE, CLEAR, RUN, DRAIN, DONE)
//   - default operand width, run timeout, settle window and counter width
//   - DSC_PROD_W  : product width for the default operand width
package dsc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } dsc_state_e;

    localparam int DSC_SNG_WIDTH = 4;
    localparam int DSC_TIMEOUT   = 64;
    localparam int DSC_SETTLE    = 2;
    localparam int DSC_CW        = 8;
    localparam int DSC_PROD_W    = 2 * DSC_SNG_WIDTH;

endpackage

// File: rtl/dsc_run_ctr.sv
// Saturating RUN-cycle counter for the multiplier sequencer.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   clr      in   synchronous clear to zero (has priority over en)
//   en       in   count enable (one count per RUN cycle)
//   cnt      out  current count (RUN cycles already completed)
//   cnt_nxt  out  count including the current cycle, saturated at TIMEOUT
//   tc       out  terminal count: this enabled cycle brings the count to TIMEOUT-1
module dsc_run_ctr
    import dsc_pkg::*;
#(
    parameter int CW      = DSC_CW,
    parameter int TIMEOUT = DSC_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          tc
);

    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        cnt_inc = (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_inc;
    // Compared against the post-increment value so the counter ends at
    // exactly TIMEOUT-1 after TIMEOUT-1 enabled cycles.
    assign tc      = en && (cnt_inc == TERM);

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequencer for one stochastic-computing multiplier datapath.
// Accepts an operand pair, clears and runs the datapath until its overflow /
// early-shutoff flag (or a timeout), drains the accumulator and returns the
// product.
// Optional build macro: DSC_MUL_SEQ_ZERO_BYPASS_EN -- a zero operand skips the
// datapath and produces a zero result one cycle after the handshake.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a, in_b operands
//   out_valid/out_ready result handshake; out_z product, out_cyc RUN cycles,
//                       out_to result ended by timeout
//   mul_a, mul_b        registered operands to the datapath
//   mul_rst, mul_en     datapath clear (active-high) and enable
//   mul_z, mul_ov       datapath accumulator and overflow flag
module dsc_mul_seq
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH = DSC_SNG_WIDTH,
    parameter int TIMEOUT   = DSC_TIMEOUT,
    parameter int SETTLE    = DSC_SETTLE,
    parameter int CW        = DSC_CW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SNG_WIDTH-1:0]   in_a,
    input  logic [SNG_WIDTH-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*SNG_WIDTH-1:0] out_z,
    output logic [CW-1:0]          out_cyc,
    output logic                   out_to,
    output logic [SNG_WIDTH-1:0]   mul_a,
    output logic [SNG_WIDTH-1:0]   mul_b,
    output logic                   mul_rst,
    output logic                   mul_en,
    input  logic [2*SNG_WIDTH-1:0] mul_z,
    input  logic                   mul_ov
);

    localparam int PW = 2 * SNG_WIDTH;

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_CLEAR = S_CLEAR;
    localparam logic [2:0] ST_RUN   = S_RUN;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_DONE  = S_DONE;

    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

    logic [2:0]           state_q, state_d;
    logic [SNG_WIDTH-1:0] a_q, a_d;
    logic [SNG_WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]        z_q, z_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic                 to_q, to_d;
    logic                 run_to_q, run_to_d;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
    logic                 byp_q, byp_d;
`endif

    logic          ctr_clr;
    logic          ctr_en;
    logic [CW-1:0] ctr_cnt;
    logic [CW-1:0] ctr_cnt_nxt;
    logic          ctr_tc;

    assign ctr_en = (state_q == ST_RUN);

    dsc_run_ctr #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_run_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .cnt     (ctr_cnt),
        .cnt_nxt (ctr_cnt_nxt),
        .tc      (ctr_tc)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        cyc_d    = cyc_q;
        to_d     = to_q;
        run_to_d = run_to_q;
        ctr_clr  = 1'b0;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
        byp_d    = byp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    ctr_clr  = 1'b1;
                    run_to_d = 1'b0;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
                    if ((in_a == '0) || (in_b == '0)) begin
                        state_d = ST_DONE;
                        z_d     = '0;
                        cyc_d   = '0;
                        to_d    = 1'b0;
                        byp_d   = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                        byp_d   = 1'b0;
                    end
`else
                    state_d = ST_CLEAR;
`endif
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // The overflow exit is checked first so it wins over a
                // simultaneous timeout. cnt_nxt counts the current cycle.
                if (mul_ov && (ctr_cnt_nxt >= SETTLE_C)) begin
                    state_d  = ST_DRAIN;
                    run_to_d = 1'b0;
                end else if (ctr_tc) begin
                    state_d  = ST_DRAIN;
                    run_to_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The accumulator register has caught up with the last
                // enabled cycle by now.
                z_d     = mul_z;
                cyc_d   = ctr_cnt;
                to_d    = run_to_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
                    byp_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            cyc_q    <= '0;
            to_q     <= 1'b0;
            run_to_q <= 1'b0;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
            byp_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
            cyc_q    <= cyc_d;
            to_q     <= to_d;
            run_to_q <= run_to_d;
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
            byp_q    <= byp_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_z     = z_q;
    assign out_cyc   = cyc_q;
    assign out_to    = to_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_en    = (state_q == ST_RUN);
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
    // A bypassed operation never releases the datapath from clear.
    assign mul_rst   = (state_q == ST_IDLE) || (state_q == ST_CLEAR) ||
                       ((state_q == ST_DONE) && byp_q);
`else
    assign mul_rst   = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
`endif

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Self-checking bench for dsc_mul_seq with a behavioural datapath model.
module tb_dsc_mul_seq;

    localparam int W  = 4;
    localparam int PW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_z;
    logic [CW-1:0] out_cyc;
    logic          out_to;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_rst;
    logic          mul_en;
    logic [PW-1:0] mul_z = '0;
    logic          mul_ov;

    always #5 clk = ~clk;

    dsc_mul_seq #(
        .SNG_WIDTH (W),
        .TIMEOUT   (64),
        .SETTLE    (2),
        .CW        (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_cyc   (out_cyc),
        .out_to    (out_to),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_rst   (mul_rst),
        .mul_en    (mul_en),
        .mul_z     (mul_z),
        .mul_ov    (mul_ov)
    );

    // Datapath model: raises mul_ov in 1-based RUN cycle ov_at and onward
    // (0 = never); the accumulator counts enabled cycles and loads z_val on
    // the cycle mul_ov is seen, visible one cycle later.
    int ov_at  = 0;
    int z_val  = 0;
    int run_cnt = 0;
    int en_cnt  = 0;
    int cyc_no  = 0;

    assign mul_ov = (ov_at != 0) && mul_en && ((run_cnt + 1) >= ov_at);

    always @(posedge clk) begin
        cyc_no <= cyc_no + 1;
        if (mul_rst) begin
            run_cnt <= 0;
            en_cnt  <= 0;
            mul_z   <= '0;
        end else if (mul_en) begin
            run_cnt <= run_cnt + 1;
            en_cnt  <= en_cnt + 1;
            mul_z   <= mul_ov ? PW'(z_val) : mul_z + 8'd1;
        end
    end

    typedef struct {
        string nm;
        int    z;
        int    cyc;
        int    to;
        int    lat;
        int    en;
        int    hs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per result handshake.
    logic valid_prev = 1'b0;
    int   first_cyc  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid) begin
            if (!valid_prev) first_cyc = cyc_no;
            if (out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got z=%0d with nothing expected", out_z);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, ".out_z"},   int'(out_z),   e.z);
                    chk({e.nm, ".out_cyc"}, int'(out_cyc), e.cyc);
                    chk({e.nm, ".out_to"},  int'(out_to),  e.to);
                    chk({e.nm, ".latency"}, first_cyc - e.hs, e.lat);
                    chk({e.nm, ".en_cycles"}, en_cnt, e.en);
                end
            end
        end
        valid_prev = rst && out_valid;
    end

    // Latency is counted from the handshake edge to the first edge after
    // which out_valid is visible: CLEAR + RUN + DRAIN cycles (0 for bypass).
    task automatic run_op(input string nm, input int a, input int b,
                          input int ova, input int zv,
                          input int ez, input int ec, input int eto,
                          input int elat, input int een, input int hold);
        exp_t e;
        ov_at     = ova;
        z_val     = zv;
        chk({nm, ".in_ready_idle"}, int'(in_ready), 1);
        in_a      = W'(a);
        in_b      = W'(b);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        e.nm = nm; e.z = ez; e.cyc = ec; e.to = eto;
        e.lat = elat; e.en = een; e.hs = cyc_no;
        sb.push_back(e);
        chk({nm, ".mul_a"}, int'(mul_a), a);
        chk({nm, ".mul_b"}, int'(mul_b), b);
        if (hold > 0) begin
            for (int i = 0; i < 300 && !out_valid; i++) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_a     = 4'd1;
            in_b     = 4'd1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({nm, ".hold_in_ready"},  int'(in_ready),  0);
                chk({nm, ".hold_out_valid"}, int'(out_valid), 1);
                chk({nm, ".hold_out_z"},     int'(out_z),     ez);
                chk({nm, ".hold_out_cyc"},   int'(out_cyc),   ec);
                chk({nm, ".hold_out_to"},    int'(out_to),    eto);
                @(posedge clk); #1;
            end
            chk({nm, ".hold_mul_a"}, int'(mul_a), a);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk({nm, ".rel_mul_rst"},   int'(mul_rst),   1);
            chk({nm, ".rel_out_valid"}, int'(out_valid), 0);
            chk({nm, ".rel_in_ready"},  int'(in_ready),  1);
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: got no result, expected one within 300 cycles", nm);
            sb.delete();
        end
        out_ready = 1'b1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".in_ready"},  int'(in_ready),  1);
        chk({nm, ".out_valid"}, int'(out_valid), 0);
        chk({nm, ".out_z"},     int'(out_z),     0);
        chk({nm, ".out_cyc"},   int'(out_cyc),   0);
        chk({nm, ".out_to"},    int'(out_to),    0);
        chk({nm, ".mul_a"},     int'(mul_a),     0);
        chk({nm, ".mul_b"},     int'(mul_b),     0);
        chk({nm, ".mul_rst"},   int'(mul_rst),   1);
        chk({nm, ".mul_en"},    int'(mul_en),    0);
    endtask

    initial begin
        #2;
        chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 3*7 with overflow in RUN cycle 6: 1 + 6 + 1 cycles to result.
        run_op("mul3x7", 3, 7, 6, 21, 21, 6, 0, 8, 6, 0);

        // Overflow from the first RUN cycle is ignored until the count reaches SETTLE.
        run_op("settle", 2, 5, 1, 10, 10, 2, 0, 4, 2, 0);

        // No overflow: forced stop after TIMEOUT-1 RUN cycles, accumulator = 63.
        run_op("timeout", 15, 15, 0, 0, 63, 63, 1, 65, 63, 0);

        // Overflow on the same cycle as the terminal count: overflow wins.
        run_op("ov_at_tc", 9, 11, 63, 99, 99, 63, 0, 65, 63, 0);

        // Consumer stalls 10 cycles in DONE.
        run_op("hold", 4, 6, 3, 24, 24, 3, 0, 5, 3, 10);

        // Reset pulse in the middle of RUN discards the operation.
        ov_at    = 0;
        in_a     = 4'd12;
        in_b     = 4'd13;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrun.mul_en_before", int'(mul_en), 1);
        rst = 1'b0;
        #1;
        chk_reset_vals("midrun_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 5, 9, 4, 45, 45, 4, 0, 6, 4, 0);

`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
        run_op("zero_byp", 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        run_op("zero_full", 0, 9, 5, 0, 0, 5, 0, 7, 5, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
